// File: rtl/debug_trace_tx.sv
// Serial trace transmitter: captures changes of a debug value into a small FIFO
// and sends each entry as a UART-style frame (start, LSB-first data, stop).
module debug_trace_tx #(
    parameter int OPERAND_SIZE = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [OPERAND_SIZE-1:0]       debug_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW  = (OPERAND_SIZE > 1) ? $clog2(OPERAND_SIZE) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]              state_r, state_nxt_s;
    logic                    tx_r, tx_nxt_s;
    logic                    busy_r, busy_nxt_s;
    logic                    overflow_r;
    logic [OPERAND_SIZE-1:0] shift_r, shift_nxt_s;
    logic [BCW-1:0]          bit_cnt_r, bit_cnt_nxt_s;
    logic [IW-1:0]           idx_r, idx_nxt_s;
    logic [OPERAND_SIZE-1:0] last_val_r;
    logic [OPERAND_SIZE-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]           count_r, count_nxt_s;

    logic detect_s, full_s, empty_s, bit_end_s, pop_s, push_ok_s, drop_s;

    // Capture and FIFO status decode; pops only see the registered count, so no bypass.
    always_comb begin
        detect_s  = enable && (debug_in != last_val_r);
        full_s    = (count_r == CW'(FIFO_DEPTH));
        empty_s   = (count_r == {CW{1'b0}});
        bit_end_s = (bit_cnt_r == BCW'(CLKS_PER_BIT - 1));
    end

    // Transmit FSM next-state, shift register and bit timing.
    always_comb begin
        state_nxt_s   = state_r;
        tx_nxt_s      = tx_r;
        shift_nxt_s   = shift_r;
        idx_nxt_s     = idx_r;
        pop_s         = 1'b0;
        if (state_r == ST_IDLE) begin
            bit_cnt_nxt_s = {BCW{1'b0}};
        end else if (bit_end_s) begin
            bit_cnt_nxt_s = {BCW{1'b0}};
        end else begin
            bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
        end
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_START;
                    tx_nxt_s    = 1'b0;
                    shift_nxt_s = mem_r[rd_ptr_r];
                end else begin
                    tx_nxt_s    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_DATA;
                    tx_nxt_s    = shift_r[0];
                    shift_nxt_s = shift_r >> 1;
                    idx_nxt_s   = {IW{1'b0}};
                end else begin
                    tx_nxt_s    = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (idx_r == IW'(OPERAND_SIZE - 1))) begin
                    state_nxt_s = ST_STOP;
                    tx_nxt_s    = 1'b1;
                end else if (bit_end_s) begin
                    tx_nxt_s    = shift_r[0];
                    shift_nxt_s = shift_r >> 1;
                    idx_nxt_s   = idx_r + IW'(1);
                end else begin
                    tx_nxt_s    = tx_r;
                end
            end
            ST_STOP: begin
                if (bit_end_s && !empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_START;
                    tx_nxt_s    = 1'b0;
                    shift_nxt_s = mem_r[rd_ptr_r];
                end else if (bit_end_s) begin
                    state_nxt_s = ST_IDLE;
                    tx_nxt_s    = 1'b1;
                end else begin
                    tx_nxt_s    = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                tx_nxt_s    = 1'b1;
            end
        endcase
    end

    // FIFO occupancy: a push into a full FIFO only succeeds if a pop frees a slot that edge.
    always_comb begin
        push_ok_s = detect_s && (!full_s || pop_s);
        drop_s    = detect_s && full_s && !pop_s;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE) || (count_nxt_s != {CW{1'b0}});
    end

    // Transmitter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            shift_r   <= {OPERAND_SIZE{1'b0}};
            bit_cnt_r <= {BCW{1'b0}};
            idx_r     <= {IW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            tx_r      <= tx_nxt_s;
            busy_r    <= busy_nxt_s;
            shift_r   <= shift_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            idx_r     <= idx_nxt_s;
        end
    end

    // Capture FIFO, change-detect register and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {OPERAND_SIZE{1'b0}};
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            last_val_r <= {OPERAND_SIZE{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (detect_s) begin
                last_val_r <= debug_in;
            end
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= debug_in;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_debug_trace_tx.sv
// Directed self-checking bench for debug_trace_tx (8-bit operand, 4 clocks/bit, 4-entry FIFO).
module tb_debug_trace_tx;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] debug_in = 8'h00;
    logic       tx, busy, overflow;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    int quiet;

    debug_trace_tx #(
        .OPERAND_SIZE (8),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .debug_in   (debug_in),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at the negedge k0 cycles after the pop edge; returns at the negedge 40 cycles after it.
    task automatic expect_frame(input logic [7:0] val, input int k0, input bit toggle);
        for (int k = k0; k < 40; k++) begin
            logic e;
            if (k < 4)       e = 1'b0;
            else if (k < 36) e = val[(k - 4) / 4];
            else             e = 1'b1;
            check_eq("frame_tx", {31'd0, tx}, {31'd0, e});
            check_eq("frame_busy", {31'd0, busy}, 32'd1);
            if (toggle) debug_in = k[0] ? 8'h10 : 8'h20;
            @(negedge clk);
        end
    endtask

    initial begin
        // Asynchronous reset with the clock stopped
        #2 reset = 1'b0;
        #2;
        check_eq("rst_noclk_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_noclk_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_noclk_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rst_noclk_cnt", {29'd0, fifo_count}, 32'd0);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_clk_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_clk_cnt", {29'd0, fifo_count}, 32'd0);
        reset = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_tx", {31'd0, tx}, 32'd1);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        // Single frame 0xA5
        debug_in = 8'hA5;
        @(negedge clk);
        check_eq("push_cnt", {29'd0, fifo_count}, 32'd1);
        check_eq("push_busy", {31'd0, busy}, 32'd1);
        check_eq("push_tx_high", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check_eq("tx_fall_latency", {31'd0, tx}, 32'd0);
        check_eq("pop_cnt", {29'd0, fifo_count}, 32'd0);
        expect_frame(8'hA5, 0, 1'b0);
        check_eq("after_frame_busy", {31'd0, busy}, 32'd0);
        check_eq("after_frame_tx", {31'd0, tx}, 32'd1);

        // Held value produces nothing
        quiet = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_count !== 3'd0) quiet++;
        end
        check_eq("hold_quiet", quiet, 32'd0);

        // Burst 0x01..0x06: 0x06 dropped
        debug_in = 8'h01;
        @(negedge clk);
        debug_in = 8'h02;
        @(negedge clk);
        for (int i = 3; i <= 6; i++) begin
            check_eq("burst_start_tx", {31'd0, tx}, 32'd0);
            debug_in = i[7:0];
            @(negedge clk);
        end
        check_eq("burst_overflow", {31'd0, overflow}, 32'd1);
        check_eq("burst_full_cnt", {29'd0, fifo_count}, 32'd4);
        expect_frame(8'h01, 4, 1'b0);
        for (int v = 2; v <= 5; v++) begin
            expect_frame(v[7:0], 0, 1'b0);
        end
        check_eq("burst_end_busy", {31'd0, busy}, 32'd0);
        check_eq("burst_end_tx", {31'd0, tx}, 32'd1);
        check_eq("burst_end_cnt", {29'd0, fifo_count}, 32'd0);
        check_eq("overflow_sticky", {31'd0, overflow}, 32'd1);

        // enable=0 suppresses capture
        enable = 1'b0;
        quiet = 0;
        repeat (20) begin
            debug_in = (debug_in == 8'h10) ? 8'h20 : 8'h10;
            @(negedge clk);
            if (tx !== 1'b1 || fifo_count !== 3'd0) quiet++;
        end
        check_eq("enable_off_quiet", quiet, 32'd0);

        // enable dropped mid-frame: frame completes intact
        enable = 1'b1;
        debug_in = 8'h3C;
        @(negedge clk);
        enable = 1'b0;
        debug_in = 8'h10;
        @(negedge clk);
        check_eq("dis_tx_fall", {31'd0, tx}, 32'd0);
        expect_frame(8'h3C, 0, 1'b1);
        check_eq("dis_end_cnt", {29'd0, fifo_count}, 32'd0);
        check_eq("dis_end_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of DATA with two entries queued
        enable = 1'b1;
        debug_in = 8'h11;
        @(negedge clk);
        debug_in = 8'h22;
        @(negedge clk);
        debug_in = 8'h33;
        @(negedge clk);
        repeat (9) @(negedge clk);
        check_eq("queued_before_rst", {29'd0, fifo_count}, 32'd2);
        check_eq("data_bit1_tx", {31'd0, tx}, 32'd0);
        #2 reset = 1'b0;
        debug_in = 8'h00;
        #1;
        check_eq("midrst_tx", {31'd0, tx}, 32'd1);
        check_eq("midrst_cnt", {29'd0, fifo_count}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        quiet = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) quiet++;
        end
        check_eq("post_rst_quiet", quiet, 32'd0);

        // First capture after release
        debug_in = 8'h5A;
        @(negedge clk);
        check_eq("first_capture_cnt", {29'd0, fifo_count}, 32'd1);
        @(negedge clk);
        check_eq("first_capture_tx", {31'd0, tx}, 32'd0);
        expect_frame(8'h5A, 0, 1'b0);
        check_eq("final_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debug_trace_tx.md
DEBUG_TRACE_TX -- requirements
Module: debug_trace_tx

Interface
REQ-001 Parameter OPERAND_SIZE, default 8: width of the traced value, matching the core's `operand_size.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, minimum 1.
REQ-003 Parameter FIFO_DEPTH, default 4: capture FIFO entries, power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 clears all state immediately, 1 runs.
REQ-006 enable  input  1  1 = capture changes of debug_in; 0 = capture suspended.
REQ-007 debug_in  input  OPERAND_SIZE  value to trace; connects to the microcontroller debug_output.
REQ-008 tx  output  1  serial line, idle high, registered.
REQ-009 busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-010 overflow  output  1  sticky flag; set when a capture is dropped.
REQ-011 fifo_count  output  clog2(FIFO_DEPTH)+1  number of entries held in the FIFO.

Function
REQ-012 Change detect: sample edge with enable=1 and debug_in != last_val -> push debug_in and set last_val=debug_in; last_val resets to 0.
REQ-013 enable=0: no push and no last_val update; a frame in progress completes; FIFO continues to drain.
REQ-014 FSM states: IDLE, START, DATA, STOP; reset state IDLE.
REQ-015 IDLE with FIFO non-empty: pop at that edge, load shift register, go to START; tx=0 from that edge.
REQ-016 Each bit: held CLKS_PER_BIT cycles via a bit counter that wraps to 0 on the last cycle of the bit.
REQ-017 DATA: OPERAND_SIZE bits, LSB first; bit index runs 0..OPERAND_SIZE-1, then STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; at the end, pop and go to START if the FIFO is non-empty (no gap between frames), else go to IDLE.
REQ-019 Frame length is (OPERAND_SIZE+2)*CLKS_PER_BIT cycles; tx falls 2 edges after a changed debug_in is presented (push edge, then pop edge).
REQ-020 FIFO full, push with no pop at the same edge: data dropped, overflow=1, fifo_count unchanged.
REQ-021 FIFO full, push and pop at the same edge: both succeed; no overflow.
REQ-022 Push into an empty FIFO while the FSM is idle: push at edge N, pop at edge N+1; no same-edge bypass.
REQ-023 overflow is cleared only by reset.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.

Reset
REQ-025 reset=0 forces, asynchronously: tx=1, busy=0, overflow=0, fifo_count=0, state IDLE, last_val=0, counters 0.
REQ-026 Reset during a frame aborts the frame; no partial frame resumes after release; FIFO contents are discarded.
REQ-027 First capture after release: any debug_in != 0 with enable=1 triggers a push on the first rising edge.

Verification (OPERAND_SIZE=8, CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Reset held low -> tx=1, busy=0, overflow=0, fifo_count=0; also asserted with clk stopped.
REQ-029 Single frame: debug_in 0x00->0xA5, enable=1 -> tx low 2 edges later; data bits 1,0,1,0,0,1,0,1, 4 cycles each; stop=1; frame 40 cycles; busy falls after stop.
REQ-030 debug_in held at 0xA5 for 200 cycles after the first frame -> no further frame; fifo_count stays 0.
REQ-031 Burst: 0x01..0x06 on consecutive edges -> 0x06 dropped, overflow=1; frames 0x01..0x05 sent back to back, 200 cycles total.
REQ-032 enable=0 with debug_in toggling 0x10/0x20 -> no push; enable dropped mid-frame -> the current frame completes intact.
REQ-033 reset=0 mid-DATA with 2 entries queued -> tx=1 immediately, fifo_count=0; after release, tx stays high with debug_in=0.
